parametric_demux_bank: RTL and testbench

- Write-side counterpart of the packed-bus word selector: accepts addressed single-word writes over a valid/ready handshake.
- Scatters each word into a register bank exposed as one packed bus of mem_depth words, so the bank can feed the selector's data_in directly.
- Tracks a per-entry valid bit and provides a sequenced clear that walks the bank one entry per cycle.
- Used for small register files, CSR shadow banks and lookup tables in the core.

---
 rtl/parametric_demux_bank_pkg.sv | 4 +
 rtl/parametric_demux_bank_demux_decoder.sv | 16 +
 rtl/parametric_demux_bank.sv | 56 +++++
 tb/tb_parametric_demux_bank.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/parametric_demux_bank_pkg.sv
// parametric_demux_bank_pkg: shared FSM state type for the demux bank
package parametric_demux_bank_pkg;
  typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/parametric_demux_bank_demux_decoder.sv
// demux_decoder: word index to one-hot write enables plus out-of-range flag
module demux_decoder #(
  parameter int mem_depth = 16,
  parameter int aw = $clog2(mem_depth)
) (
  input  logic [aw-1:0]        addr,
  output logic [mem_depth-1:0] onehot,
  output logic                 out_of_range
);
  localparam logic [aw:0] depth_v = (aw+1)'(mem_depth);
  always_comb begin
    onehot = '0;
    for (int i = 0; i < mem_depth; i++) onehot[i] = addr == aw'(i);
  end
  assign out_of_range = {1'b0, addr} >= depth_v;
endmodule

// File: rtl/parametric_demux_bank.sv
// parametric_demux_bank: addressed single-word writes scattered into a packed register bank
module parametric_demux_bank
  import parametric_demux_bank_pkg::*;
#(
  parameter int mem_width = 16,
  parameter int mem_depth = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [$clog2(mem_depth)-1:0]   wr_addr,
  input  logic [mem_width-1:0]           wr_data,
  input  logic                           clear_req,
  output logic                           clear_busy,
  output logic                           wr_err,
  output logic [mem_depth-1:0]           valid_out,
  output logic [mem_width*mem_depth-1:0] data_out
);
  localparam int aw = $clog2(mem_depth);
  state_t state, state_nx;
  logic [aw-1:0] idx;
  logic [mem_depth-1:0] wr_hot, wen, clr;
  logic wr_oor, accept, last;
  logic [mem_depth-1:0][mem_width-1:0] bank;
  demux_decoder #(.mem_depth(mem_depth)) u_dec (.addr(wr_addr), .onehot(wr_hot), .out_of_range(wr_oor));
  assign wr_ready   = state == IDLE && !clear_req;
  assign accept     = wr_valid && wr_ready;
  assign clear_busy = state == CLEAR;
  assign last       = idx == aw'(mem_depth - 1);
  assign wen        = accept ? wr_hot : '0;
  assign clr        = clear_busy ? mem_depth'(1) << idx : '0;
  assign data_out   = bank;
  always_comb begin
    state_nx = state;
    if (state == IDLE && clear_req) state_nx = CLEAR;
    if (state == CLEAR && last) state_nx = IDLE;
  end
  // the clear walk and writes never coincide: writes are only accepted in IDLE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      wr_err    <= 1'b0;
      valid_out <= '0;
      bank      <= '0;
    end else begin
      state     <= state_nx;
      idx       <= clear_busy && !last ? idx + 1'b1 : '0;
      wr_err    <= accept && wr_oor;
      valid_out <= (valid_out | wen) & ~clr;
      for (int i = 0; i < mem_depth; i++)
        if (clr[i]) bank[i] <= '0;
        else if (wen[i]) bank[i] <= wr_data;
    end
endmodule

// File: tb/tb_parametric_demux_bank.sv
// tb_parametric_demux_bank: scoreboard bench for 16-deep and 12-deep banks
module tb_parametric_demux_bank;
  localparam int W = 16, D = 16, DB = 12;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic wr_valid = 0, clear_req = 0, wr_ready, clear_busy, wr_err;
  logic [3:0] wr_addr = 0;
  logic [W-1:0] wr_data = 0;
  logic [D-1:0] valid_out;
  logic [W*D-1:0] data_out;
  logic wr_valid_b = 0, clear_req_b = 0, wr_ready_b, clear_busy_b, wr_err_b;
  logic [3:0] wr_addr_b = 0;
  logic [W-1:0] wr_data_b = 0;
  logic [DB-1:0] valid_out_b;
  logic [W*DB-1:0] data_out_b;

  parametric_demux_bank #(.mem_width(W), .mem_depth(D)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .clear_req(clear_req), .clear_busy(clear_busy), .wr_err(wr_err),
    .valid_out(valid_out), .data_out(data_out));
  parametric_demux_bank #(.mem_width(W), .mem_depth(DB)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid_b), .wr_ready(wr_ready_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .clear_req(clear_req_b), .clear_busy(clear_busy_b), .wr_err(wr_err_b),
    .valid_out(valid_out_b), .data_out(data_out_b));

  typedef struct {int addr; logic [W-1:0] data;} wr_t;
  wr_t sb[$];
  logic [W-1:0] mdl[D];
  logic [D-1:0] mvld;
  int vectors = 0, errors = 0;

  function automatic logic [W*D-1:0] mbus();
    logic [W*D-1:0] b;
    for (int i = 0; i < D; i++) b[i*W +: W] = mdl[i];
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D; i++) mdl[i] = '0;
    mvld = '0;
    sb.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drives one write on the 16-deep bank and books the expected result
  task automatic push_write(input int a, input logic [W-1:0] d);
    wr_valid = 1;
    wr_addr = 4'(a);
    wr_data = d;
    sb.push_back('{a, d});
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_clear();
    tick();
    vectors++; if (data_out !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_out); end
    vectors++; if (valid_out !== '0) begin errors++; $display("FAIL reset_valid got=%h exp=0", valid_out); end
    vectors++; if ({clear_busy, wr_err, wr_ready} !== 3'b001) begin errors++; $display("FAIL reset_ctrl got=%b exp=001", {clear_busy, wr_err, wr_ready}); end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    wr_t t;
    push_write(3, 16'h1234);
    push_write(15, 16'hBEEF);
    wr_valid = 0;
    while (sb.size() > 0) begin
      t = sb.pop_front();
      mdl[t.addr] = t.data;
      mvld[t.addr] = 1;
      vectors++; if (data_out[t.addr*W +: W] !== t.data) begin errors++; $display("FAIL basic_word%0d got=%h exp=%h", t.addr, data_out[t.addr*W +: W], t.data); end
    end
    vectors++; if (data_out !== mbus()) begin errors++; $display("FAIL basic_bus got=%h exp=%h", data_out, mbus()); end
    vectors++; if (valid_out !== 16'h8008) begin errors++; $display("FAIL basic_valid got=%h exp=8008", valid_out); end
  endtask

  task automatic test_back_to_back();
    wr_t t;
    for (int k = 1; k <= 2; k++) begin
      push_write(5, W'(k));
      t = sb.pop_front();
      mdl[t.addr] = t.data;
      mvld[t.addr] = 1;
      vectors++; if (data_out[5*W +: W] !== t.data) begin errors++; $display("FAIL b2b_word5 got=%h exp=%h", data_out[5*W +: W], t.data); end
      vectors++; if (valid_out !== mvld) begin errors++; $display("FAIL b2b_valid got=%h exp=%h", valid_out, mvld); end
    end
    wr_valid = 0;
  endtask

  task automatic fill_all();
    wr_t t;
    for (int k = 0; k < D; k++) begin
      push_write(k, 16'h1000 + W'(k));
      t = sb.pop_front();
      mdl[t.addr] = t.data;
      mvld[t.addr] = 1;
    end
    wr_valid = 0;
    vectors++; if (data_out !== mbus()) begin errors++; $display("FAIL fill_bus got=%h exp=%h", data_out, mbus()); end
    vectors++; if (valid_out !== mvld) begin errors++; $display("FAIL fill_valid got=%h exp=%h", valid_out, mvld); end
  endtask

  task automatic test_clear();
    fill_all();
    clear_req = 1;
    wr_valid = 1;
    wr_addr = 0;
    wr_data = 16'hFFFF;
    #1;
    vectors++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL clear_ready got=%b exp=0", wr_ready); end
    tick();
    clear_req = 0;
    wr_valid = 0;
    vectors++; if (data_out !== mbus()) begin errors++; $display("FAIL clear_nowrite got=%h exp=%h", data_out, mbus()); end
    for (int k = 0; k < D; k++) begin
      vectors++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL clear_busy%0d got=%b exp=1", k, clear_busy); end
      tick();
      mdl[k] = '0;
      mvld[k] = 0;
      vectors++; if (data_out !== mbus() || valid_out !== mvld) begin errors++; $display("FAIL clear_step%0d got=%h/%h exp=%h/%h", k, data_out, valid_out, mbus(), mvld); end
    end
    vectors++; if ({clear_busy, wr_ready} !== 2'b01) begin errors++; $display("FAIL clear_done got=%b exp=01", {clear_busy, wr_ready}); end
    vectors++; if (data_out !== '0 || valid_out !== '0) begin errors++; $display("FAIL clear_empty got=%h/%h exp=0/0", data_out, valid_out); end
  endtask

  task automatic test_range();
    logic [W*DB-1:0] d_snap;
    logic [DB-1:0] v_snap;
    wr_valid_b = 1; wr_addr_b = 2; wr_data_b = 16'h5555;
    tick();
    d_snap = data_out_b;
    v_snap = valid_out_b;
    vectors++; if (data_out_b[2*W +: W] !== 16'h5555) begin errors++; $display("FAIL range_word2 got=%h exp=5555", data_out_b[2*W +: W]); end
    wr_addr_b = 13; wr_data_b = 16'hAAAA;
    tick();
    wr_valid_b = 0;
    vectors++; if (wr_err_b !== 1'b1) begin errors++; $display("FAIL range_err got=%b exp=1", wr_err_b); end
    vectors++; if (data_out_b !== d_snap || valid_out_b !== v_snap) begin errors++; $display("FAIL range_unchanged got=%h/%h exp=%h/%h", data_out_b, valid_out_b, d_snap, v_snap); end
    tick();
    vectors++; if (wr_err_b !== 1'b0) begin errors++; $display("FAIL range_err_pulse got=%b exp=0", wr_err_b); end
    wr_valid_b = 1; wr_addr_b = 11;
    tick();
    wr_valid_b = 0;
    vectors++; if (wr_err_b !== 1'b0) begin errors++; $display("FAIL range_err11 got=%b exp=0", wr_err_b); end
    vectors++; if (data_out_b[11*W +: W] !== 16'hAAAA || valid_out_b !== 12'h804) begin errors++; $display("FAIL range_word11 got=%h/%h exp=aaaa/804", data_out_b[11*W +: W], valid_out_b); end
  endtask

  task automatic test_reset_mid_clear();
    wr_t t;
    fill_all();
    clear_req = 1;
    tick();
    clear_req = 0;
    for (int k = 0; k < 6; k++) tick();
    rst_n = 0;
    model_clear();
    #1;
    vectors++; if (data_out !== '0 || valid_out !== '0) begin errors++; $display("FAIL rstmid_outs got=%h/%h exp=0/0", data_out, valid_out); end
    vectors++; if ({clear_busy, wr_err} !== 2'b00) begin errors++; $display("FAIL rstmid_ctrl got=%b exp=00", {clear_busy, wr_err}); end
    tick();
    tick();
    rst_n = 1;
    vectors++; if ({clear_busy, wr_ready} !== 2'b01) begin errors++; $display("FAIL rstmid_idle got=%b exp=01", {clear_busy, wr_ready}); end
    push_write(0, 16'h7777);
    wr_valid = 0;
    t = sb.pop_front();
    mdl[t.addr] = t.data;
    mvld[t.addr] = 1;
    vectors++; if (data_out !== mbus() || valid_out !== mvld) begin errors++; $display("FAIL rstmid_write got=%h/%h exp=%h/%h", data_out, valid_out, mbus(), mvld); end
  endtask

  task automatic test_clear_hold();
    clear_req = 1;
    tick();
    for (int k = 0; k < D; k++) begin
      vectors++; if ({clear_busy, wr_ready} !== 2'b10) begin errors++; $display("FAIL hold_busy%0d got=%b exp=10", k, {clear_busy, wr_ready}); end
      tick();
    end
    vectors++; if ({clear_busy, wr_ready} !== 2'b00) begin errors++; $display("FAIL hold_gap got=%b exp=00", {clear_busy, wr_ready}); end
    tick();
    vectors++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL hold_restart got=%b exp=1", clear_busy); end
    clear_req = 0;
    #1;
    vectors++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_busy got=%b exp=0", wr_ready); end
    for (int k = 1; k < D; k++) tick();
    vectors++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL hold_last got=%b exp=1", clear_busy); end
    tick();
    vectors++; if ({clear_busy, wr_ready} !== 2'b01) begin errors++; $display("FAIL hold_end got=%b exp=01", {clear_busy, wr_ready}); end
    vectors++; if (data_out !== '0 || valid_out !== '0) begin errors++; $display("FAIL hold_empty got=%h/%h exp=0/0", data_out, valid_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_clear();
    test_range();
    test_reset_mid_clear();
    test_clear_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
